// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: reset / exception / eret / stall / redirect / +4,
// with AdEL substitution of illegal fetches. Optional macro: FETCH_RANGE_CHECK_EN.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic [31:0] imem_instr,
  output logic [31:0] PC,
  output logic [31:0] if_instr,
  output logic        adel,
  output logic        in_handler,
  output logic        double_fault
);

  typedef enum logic {RUN, HANDLER} state_t;
  state_t state;

  // exc_req in HANDLER only poisons double_fault; it falls through the
  // remaining priorities as if absent.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      PC           <= RESET_PC;
      in_handler   <= 1'b0;
      double_fault <= 1'b0;
    end else begin
      if (exc_req && state == HANDLER)
        double_fault <= 1'b1;
      if (exc_req && state == RUN) begin
        PC         <= HANDLER_PC;
        state      <= HANDLER;
        in_handler <= 1'b1;
      end else if (eret_req) begin
        PC         <= epc;
        state      <= RUN;
        in_handler <= 1'b0;
      end else if (!stall) begin
        PC <= npc_valid ? npc : PC + 32'd4;
      end
    end
  end

  logic misaligned, out_of_range;
  assign misaligned = |PC[1:0];
`ifdef FETCH_RANGE_CHECK_EN
  assign out_of_range = (PC < TEXT_LO) || (PC > TEXT_HI);
`else
  assign out_of_range = 1'b0;
`endif

  assign adel     = misaligned || out_of_range;
  assign if_instr = adel ? 32'h0 : imem_instr;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: expectations queued at drive time,
// popped and compared one step after each rising edge.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset, stall, npc_valid, exc_req, eret_req;
  logic [31:0] npc, epc, imem_instr;
  logic [31:0] PC, if_instr;
  logic        adel, in_handler, double_fault;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        ih;
    logic        df;
  } exp_t;
  exp_t sb[$];

  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_valid(npc_valid), .npc(npc),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc), .imem_instr(imem_instr),
    .PC(PC), .if_instr(if_instr), .adel(adel), .in_handler(in_handler),
    .double_fault(double_fault)
  );

  always #5 clk = ~clk;

  // ROM stand-in: distinct data per address so a wrong fetch is visible.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction
  assign imem_instr = rom(PC);

  function automatic logic exp_adel(input logic [31:0] a);
    logic bad;
    bad = (a[1:0] != 2'b00);
`ifdef FETCH_RANGE_CHECK_EN
    bad = bad || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
`endif
    return bad;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Drive one cycle's inputs, queue the post-edge expectation, then check it.
  task automatic cyc(input string tag, input logic r, input logic st, input logic nv,
                     input logic [31:0] n, input logic ex, input logic er,
                     input logic [31:0] e, input logic [31:0] xpc,
                     input logic xih, input logic xdf);
    exp_t x;
    reset = r; stall = st; npc_valid = nv; npc = n;
    exc_req = ex; eret_req = er; epc = e;
    sb.push_back('{tag, xpc, xih, xdf});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.tag, ".pc"}, PC, x.pc);
    chk({x.tag, ".in_handler"}, {31'b0, in_handler}, {31'b0, x.ih});
    chk({x.tag, ".double_fault"}, {31'b0, double_fault}, {31'b0, x.df});
    chk({x.tag, ".adel"}, {31'b0, adel}, {31'b0, exp_adel(x.pc)});
    chk({x.tag, ".if_instr"}, if_instr, exp_adel(x.pc) ? 32'h0 : rom(x.pc));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; npc_valid = 1'b0; npc = '0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0;
    //  tag        rst st nv npc            ex er epc            PC             ih df
    cyc("reset",   1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 0, 0);
    cyc("seq1",    0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 0, 0);
    cyc("seq2",    0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("stall", 0, 1, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_3008, 0, 0);
    cyc("unstall", 0, 0, 0, 32'h3100,     0, 0, 32'h0,        32'h0000_300C, 0, 0);
    cyc("seq3",    0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3010, 0, 0);
    cyc("exc_stl", 0, 1, 0, 32'h0,        1, 0, 32'h0,        32'h0000_4180, 1, 0);
    cyc("eret",    0, 0, 0, 32'h0,        0, 1, 32'h3010,     32'h0000_3010, 0, 0);
    cyc("exc2",    0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0000_4180, 1, 0);
    cyc("dbl_exc", 0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0000_4184, 1, 1);
    cyc("dbl_hold",0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_4188, 1, 1);
    cyc("npc_mis", 0, 0, 1, 32'h3102,     0, 0, 32'h0,        32'h0000_3102, 1, 1);
    cyc("npc_4190",0, 0, 1, 32'h4190,     0, 0, 32'h0,        32'h0000_4190, 1, 1);
    cyc("reset2",  1, 1, 1, 32'h5000,     1, 1, 32'h6000,     32'h0000_3000, 0, 0);
    cyc("eret_run",0, 0, 1, 32'h5000,     0, 1, 32'h3001,     32'h0000_3001, 0, 0);
    cyc("npc_7000",0, 0, 1, 32'h7000,     0, 0, 32'h0,        32'h0000_7000, 0, 0);
    cyc("seq7004", 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_7004, 0, 0);
    cyc("npc_top", 0, 0, 1, 32'hFFFF_FFFC,0, 0, 32'h0,        32'hFFFF_FFFC, 0, 0);
    cyc("wrap",    0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0000, 0, 0);
    cyc("ex_er_rn",0, 0, 1, 32'h3200,     1, 1, 32'h3300,     32'h0000_4180, 1, 0);
    cyc("ex_er_hd",0, 1, 0, 32'h0,        1, 1, 32'h3020,     32'h0000_3020, 0, 1);
    cyc("run_seq", 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3024, 0, 1);
    cyc("hdl_stl", 0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0000_4180, 1, 1);
    cyc("hdl_hold",0, 1, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_4180, 1, 1);
    cyc("reset3",  1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
